pcap_dma_writer: RTL

Host-memory writer at the far end of the position-capture DMA path: drains captured 32-bit words from the capture FIFO and writes them as AXI3 bursts into host buffers supplied by the driver through the DMA address registers. For each finished or flushed buffer it raises an interrupt whose status word carries reason flags and the sample count, which the driver's IRQ handler uses to post the next buffer address. Sits between the PCAP capture FIFO and the S_AXI_HP write port.

---
 rtl/pcap_dma_writer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pcap_dma_writer.sv
// Drains captured words from the PCAP FIFO into host buffers as AXI3 write bursts,
// and raises a status interrupt each time a buffer is finished, flushed or aborted.
module pcap_dma_writer #(
  parameter int MAX_BURST = 16,
  parameter int FIFO_AW = 11
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               dma_reset_i,
  input  logic               dma_start_i,
  input  logic [31:0]        dma_addr_i,
  input  logic               dma_addr_wstb_i,
  input  logic [31:0]        block_size_i,
  input  logic [31:0]        timeout_i,
  input  logic               pcap_done_i,
  input  logic [31:0]        fifo_data_i,
  input  logic [FIFO_AW-1:0] fifo_count_i,
  output logic               fifo_rd_o,
  output logic [31:0]        m_awaddr_o,
  output logic [3:0]         m_awlen_o,
  output logic               m_awvalid_o,
  input  logic               m_awready_i,
  output logic [31:0]        m_wdata_o,
  output logic               m_wlast_o,
  output logic               m_wvalid_o,
  input  logic               m_wready_i,
  input  logic [1:0]         m_bresp_i,
  input  logic               m_bvalid_i,
  output logic               m_bready_o,
  output logic               irq_o,
  output logic [31:0]        irq_status_o,
  input  logic               irq_status_rstb_i,
  output logic               active_o
);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, RESP, IRQ} state_t;
  state_t state, state_nx;

  logic [31:0]   q_addr0, q_addr1, cur_addr, timer, fifo_cnt;
  logic [1:0]    q_count, pop_count;
  logic [15:0]   words;
  logic [16:0]   block_words, rem, words_acc;
  logic [BW-1:0] beats, beat_cnt, burst_nx, beats_full;
  logic [5:0]    flags, flag_set, wstb_flags;
  logic          flush_done, flush_tmo, addr_bad, push_ok, pop;
  logic          do_start, do_shift, go_addr, set_done, set_tmo, irq_again;
  logic          unused;

  assign unused      = ^{block_size_i[31:19], block_size_i[1:0]};
  assign block_words = block_size_i[18:2];
  assign rem         = block_words - {1'b0, words};
  assign beats_full  = (rem > 17'(MAX_BURST)) ? BW'(MAX_BURST) : rem[BW-1:0];
  assign fifo_cnt    = 32'(fifo_count_i);
  assign words_acc   = {1'b0, words} + 17'(beats);

  // Handshakes: a beat/address/response moves on a clock edge where valid and ready are both high.
  assign m_awvalid_o = (state == ADDR) && !dma_reset_i;
  assign m_wvalid_o  = (state == DATA) && !dma_reset_i;
  assign m_wlast_o   = m_wvalid_o && (beat_cnt == BW'(1));
  assign m_wdata_o   = m_wvalid_o ? fifo_data_i : 32'h0;
  assign fifo_rd_o   = m_wvalid_o && m_wready_i;
  assign m_bready_o  = (state == RESP) && !dma_reset_i;
  assign active_o    = (state != IDLE);

  // Address queue bookkeeping; a pop in the same cycle frees a slot for the push.
  assign pop        = do_start || do_shift;
  assign pop_count  = q_count - {1'b0, pop};
  assign addr_bad   = (dma_addr_i[5:0] != 6'h0);
  assign push_ok    = dma_addr_wstb_i && !addr_bad && (pop_count != 2'd2);
  assign wstb_flags = {dma_addr_wstb_i && !addr_bad && (pop_count == 2'd2), 1'b0,
                       dma_addr_wstb_i && addr_bad, 3'b000};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    burst_nx  = beats_full;
    do_start  = 1'b0;
    do_shift  = 1'b0;
    go_addr   = 1'b0;
    set_done  = 1'b0;
    set_tmo   = 1'b0;
    irq_again = 1'b0;
    flag_set  = 6'h0;
    case (state)
      IDLE: if (dma_start_i) begin
        if (q_count != 2'd0) begin
          state_nx = WAIT;
          do_start = 1'b1;
        end else begin
          state_nx    = IRQ;
          flag_set[3] = 1'b1;
        end
      end
      WAIT: begin
        if (fifo_cnt >= 32'(beats_full)) begin
          state_nx = ADDR;
          go_addr  = 1'b1;
        end else if (pcap_done_i) begin
          if (fifo_cnt != 32'h0) begin
            state_nx = ADDR;
            go_addr  = 1'b1;
            burst_nx = fifo_count_i[BW-1:0];
            set_done = 1'b1;
          end else begin
            state_nx    = IRQ;
            flag_set[1] = 1'b1;
          end
        end else if (timeout_i != 32'h0 && timer >= timeout_i &&
                     (32'(words) + fifo_cnt) != 32'h0) begin
          if (fifo_cnt != 32'h0) begin
            state_nx = ADDR;
            go_addr  = 1'b1;
            burst_nx = fifo_count_i[BW-1:0];
            set_tmo  = 1'b1;
          end else begin
            state_nx    = IRQ;
            flag_set[2] = 1'b1;
          end
        end
      end
      ADDR: if (m_awready_i) state_nx = DATA;
      DATA: if (m_wready_i && beat_cnt == BW'(1)) state_nx = RESP;
      RESP: if (m_bvalid_i) begin
        state_nx = IRQ;
        if (m_bresp_i != 2'b00)        flag_set[4] = 1'b1;
        else if (words_acc == block_words) flag_set[0] = 1'b1;
        else if (flush_done)           flag_set[1] = 1'b1;
        else if (flush_tmo)            flag_set[2] = 1'b1;
        else                           state_nx = WAIT;
      end
      IRQ: begin
        if (flags[1] || flags[3] || flags[4]) begin
          state_nx = IDLE;
        end else if (q_count != 2'd0) begin
          state_nx = WAIT;
          do_shift = 1'b1;
        end else begin
          irq_again = 1'b1;  // second status visit reports "no next buffer"
        end
      end
      default: state_nx = IDLE;
    endcase
    if (dma_reset_i) begin
      state_nx  = IDLE;
      do_start  = 1'b0;
      do_shift  = 1'b0;
      go_addr   = 1'b0;
      irq_again = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q_addr0 <= '0; q_addr1 <= '0; q_count <= '0; cur_addr <= '0;
      words <= '0; timer <= '0; beats <= '0; beat_cnt <= '0; flags <= '0;
      flush_done <= 1'b0; flush_tmo <= 1'b0;
      m_awaddr_o <= '0; m_awlen_o <= '0; irq_o <= 1'b0; irq_status_o <= '0;
    end else if (dma_reset_i) begin
      q_count <= '0; words <= '0; timer <= '0; flags <= '0;
      flush_done <= 1'b0; flush_tmo <= 1'b0;
      irq_o <= 1'b0; irq_status_o <= '0;
    end else begin
      q_count <= pop_count + {1'b0, push_ok};
      if (pop) q_addr0 <= q_addr1;
      if (push_ok) begin
        if (pop_count == 2'd0) q_addr0 <= dma_addr_i;
        else                   q_addr1 <= dma_addr_i;
      end
      if (pop) begin
        cur_addr <= q_addr0;
        words    <= '0;
      end else if (state == RESP && m_bvalid_i) begin
        words <= words_acc[15:0];
      end
      if (do_start || (state_nx == IRQ && state != IRQ)) timer <= '0;
      else if (state != IDLE && state != IRQ && timer != 32'hFFFF_FFFF) timer <= timer + 32'd1;
      if (go_addr) begin
        beats      <= burst_nx;
        beat_cnt   <= burst_nx;
        m_awaddr_o <= cur_addr + {14'h0, words, 2'b00};
        m_awlen_o  <= 4'(burst_nx - BW'(1));
      end else if (state == DATA && m_wready_i) begin
        beat_cnt <= beat_cnt - BW'(1);
      end
      if (pop || state == IRQ) begin
        flush_done <= 1'b0;
        flush_tmo  <= 1'b0;
      end else if (go_addr) begin
        flush_done <= set_done;
        flush_tmo  <= set_tmo;
      end
      if (state == IRQ) flags <= (irq_again ? 6'h08 : 6'h00) | flag_set | wstb_flags;
      else              flags <= flags | flag_set | wstb_flags;
      if (state == IRQ) begin
        irq_o        <= 1'b1;
        irq_status_o <= {8'h00, words, 2'b00, flags};
      end else if (irq_status_rstb_i) begin
        irq_o        <= 1'b0;
        irq_status_o <= '0;
      end
    end
  end
endmodule
